search_mem_arbiter: RTL and testbench
=====================================

Name: search_mem_arbiter

Overview:
- Shares the single 32x8 sorted lookup memory (synchronous read, address sampled at clk edge) between several binary-search engines.
- Round-robin arbitration per read; a requester may lock the port to run a whole search without interleaving.
- Routes the registered memory output back to the requester that issued each read.
- Sits between the search engines and the memory instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 5, memory address width
- DW, 8, memory data width
- RD_LAT, 1, cycles from address sampled to valid mem_q (1..2)
- MAX_HOLD, 16, max consecutive locked grant cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rs  in  1  synchronous active-high reset
- req  in  NREQ  per-requester read request
- lock  in  NREQ  requester asks to keep the grant after the current cycle
- addr_in  in  NREQ*AW  packed read addresses; requester i uses bits [i*AW +: AW]
- gnt  out  NREQ  one-hot registered grant
- mem_addr  out  AW  address to memory
- mem_q  in  DW  memory read data
- rdata  out  DW  returned read data, shared by all requesters
- rvalid  out  NREQ  one-hot; rdata belongs to requester i
- busy  out  1  high while any grant or read is in flight
- hold_expired  out  1  one-cycle pulse on forced lock release

Behaviour:
- Reset (rs=1 at edge): gnt=0, rvalid=0, rdata=0, hold_expired=0, busy=0, RR pointer=0, latency pipeline cleared, hold counter=0. Reset mid-read drops in-flight returns; no rvalid is produced for them.
- Port free at an edge if gnt==0, or owner's req==0, or owner's lock==0.
- When the port is free and any req is high, grant the first requester with req high, searching from pointer+1 and wrapping modulo NREQ. gnt takes effect the next cycle. Pointer then equals the new owner.
- A requester whose req rises while the port is free sees gnt 1 cycle later.
- Back-to-back: an unlocked owner releases and a new grant (possibly the same requester if it is alone) appears on the immediately following cycle. There are no bubble cycles.
- Read issue: in a cycle with gnt[i]=1 and req[i]=1:
  - mem_addr = addr_in[i], combinational.
  - Push tag i into the RD_LAT-deep pipeline.
  - If gnt is 0, or the owner's req is 0, mem_addr=0 and no tag is pushed.
- Return: RD_LAT cycles after issue, rvalid[tag]=1 and rdata = mem_q (registered). Total issue-to-rvalid latency is RD_LAT+1 cycles. Returns keep their order. rvalid is pulsed one cycle per read.
- Lock: while owner holds req and lock, gnt persists every cycle. Deasserting lock grants the final read; re-arbitration happens at the next edge.
- The owner dropping req releases the port in the same edge.
- gnt is never asserted for a requester whose req was low at the arbitration edge.
- busy = |gnt OR any valid tag in the pipeline.
- Requests from others while the port is locked are held pending; they are not lost and need no re-request.

Optional Feature:
- Macro SEARCH_MEM_ARB_HOLD_LIMIT_EN.
- Defined:
  - Counter of consecutive locked grant cycles for the current owner.
  - When it reaches MAX_HOLD and another req is pending, the port is forced free at that edge and hold_expired pulses 1 cycle.
  - The former owner is skipped in that arbitration.
  - The counter clears on any grant change.
  - With no other req pending, the lock continues and the counter saturates.
- Undefined: no counter, lock is unbounded, hold_expired tied 0.

Decomposition:
- Package search_mem_pkg:
  - SM_AW=5, SM_DW=8, SM_DEPTH=32, SM_NREQ_DEF=4.
  - Typedef for the requester index (clog2 NREQ).
  - Function onehot_to_idx.
- One sub-module: rr_pick, combinational. Inputs are req vector, pointer and exclude mask; outputs are a one-hot pick and a valid flag. Instantiated once.
- The latency pipeline and hold counter stay in the top.

Test Plan (bench memory model mem[k]=2k+1, NREQ=4, RD_LAT=1):
- Single unlocked read: req[2]=1, addr_in[2]=5 -> gnt=0100 next cycle; rvalid=0100 with rdata=11 two cycles after grant; busy high throughout.
- Round-robin: req=1111 held, no lock, pointer 0 after reset -> grant order 0010,0100,1000,0001,0010 on consecutive cycles; no idle cycles.
- Locked search: req[0]=lock[0]=1 for 5 cycles, addrs 15,7,3,5,4, req[3]=1 throughout -> gnt=0001 for 5 cycles, rdata 31,15,7,11,9, then gnt=1000.
- Reset mid-read: rs=1 on the cycle after issuing addr 9 for requester 1 -> no rvalid; gnt=0; next grant goes to requester 0 if it is requesting.
- Hold limit (macro defined, MAX_HOLD=4): req[1]=lock[1]=1 forever, req[2]=1 -> gnt[1] held 4 cycles, hold_expired pulses, gnt=0100 next cycle. Macro undefined -> gnt[1] held indefinitely, hold_expired stays 0.
- Owner drops req: lock[0]=1 and req[0] falls, req[1]=1 -> gnt=0010 next cycle; no tag pushed for the dropped cycle.

Source files
------------

// File: rtl/search_mem_pkg.sv
// Shared types and helpers for the search-memory arbiter slice.
package search_mem_pkg;

  localparam int SM_AW       = 5;
  localparam int SM_DW       = 8;
  localparam int SM_DEPTH    = 32;
  localparam int SM_NREQ_DEF = 4;
  localparam int SM_NREQ_MAX = 8;
  localparam int SM_IDX_W    = $clog2(SM_NREQ_MAX);

  typedef logic [SM_IDX_W-1:0] req_idx_t;

  function automatic req_idx_t onehot_to_idx(input logic [SM_NREQ_MAX-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int k = 0; k < SM_NREQ_MAX; k++) begin
      if (oh[k]) idx = req_idx_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible requester after ptr, wrapping.
module rr_pick
  import search_mem_pkg::*;
#(
  parameter int NREQ = SM_NREQ_DEF
) (
  input  logic [NREQ-1:0] req,
  input  req_idx_t        ptr,
  input  logic [NREQ-1:0] excl,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  logic [NREQ-1:0] cand;
  int              idx;

  assign cand = req & ~excl;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!valid && cand[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/search_mem_arbiter.sv
// Round-robin, lockable arbiter sharing one synchronous-read memory between search engines.
// Optional hold limit on locked ownership: define SEARCH_MEM_ARB_HOLD_LIMIT_EN.
module search_mem_arbiter
  import search_mem_pkg::*;
#(
  parameter int NREQ     = SM_NREQ_DEF,
  parameter int AW       = SM_AW,
  parameter int DW       = SM_DW,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rs,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*AW-1:0] addr_in,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      mem_addr,
  input  logic [DW-1:0]      mem_q,
  output logic [DW-1:0]      rdata,
  output logic [NREQ-1:0]    rvalid,
  output logic               busy,
  output logic               hold_expired
);

  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] excl;
  logic            pick_vld;
  logic            issue;
  logic            owner_locked;
  logic            forced;
  logic            port_free;
  req_idx_t        ptr;
  logic            vld_p [RD_LAT];
  req_idx_t        tag_p [RD_LAT];

  assign issue        = |(gnt & req);
  assign owner_locked = |(gnt & req & lock);
  assign port_free    = !owner_locked || forced;
  assign excl         = forced ? gnt : '0;

  always_comb begin
    mem_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i] && req[i]) mem_addr = addr_in[i*AW +: AW];
    end
  end

  always_comb begin
    busy = |gnt;
    for (int k = 0; k < RD_LAT; k++) busy = busy | vld_p[k];
  end

`ifdef SEARCH_MEM_ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;

  // hold_cnt = cycles already granted to the current owner, saturating at MAX_HOLD-1
  assign forced = owner_locked && (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && |(req & ~gnt);

  always_ff @(posedge clk) begin
    if (rs) begin
      hold_cnt     <= '0;
      hold_expired <= 1'b0;
    end else begin
      hold_expired <= forced;
      if (port_free) hold_cnt <= '0;
      else if (hold_cnt != HOLD_W'(MAX_HOLD - 1)) hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign forced       = 1'b0;
  assign hold_expired = (MAX_HOLD < 0);
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .excl  (excl),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rs) begin
      gnt    <= '0;
      ptr    <= '0;
      rvalid <= '0;
      rdata  <= '0;
      for (int k = 0; k < RD_LAT; k++) vld_p[k] <= 1'b0;
    end else begin
      if (port_free) begin
        gnt <= pick_vld ? pick : '0;
        if (pick_vld) ptr <= onehot_to_idx(SM_NREQ_MAX'(pick));
      end
      // stage p0: read issued this cycle; last stage lines up with valid mem_q
      vld_p[0] <= issue;
      for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
      rvalid <= '0;
      if (vld_p[RD_LAT-1]) begin
        rvalid <= {{(NREQ-1){1'b0}}, 1'b1} << tag_p[RD_LAT-1];
        rdata  <= mem_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= onehot_to_idx(SM_NREQ_MAX'(gnt));
    for (int k = 1; k < RD_LAT; k++) tag_p[k] <= tag_p[k-1];
  end

endmodule

// File: tb/tb_search_mem_arbiter.sv
// Directed bench for search_mem_arbiter with a scoreboard of expected read returns.
module tb_search_mem_arbiter;
  import search_mem_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rs;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ*AW-1:0] addr_in;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_q;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    rvalid;
  logic               busy;
  logic               hold_expired;

  logic [DW-1:0] mem [SM_DEPTH];
  logic [15:0]   sb [$];
  int checks = 0;
  int errors = 0;

  search_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1), .MAX_HOLD(4)) dut (
    .clk          (clk),
    .rs           (rs),
    .req          (req),
    .lock         (lock),
    .addr_in      (addr_in),
    .gnt          (gnt),
    .mem_addr     (mem_addr),
    .mem_q        (mem_q),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .busy         (busy),
    .hold_expired (hold_expired)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < SM_DEPTH; k++) mem[k] = DW'(2 * k + 1);
  end

  always @(posedge clk) mem_q <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input int a);
    addr_in[i*AW +: AW] = AW'(a);
  endtask

  task automatic push(input int idx, input int a);
    sb.push_back({8'(idx), mem[a]});
  endtask

  // Return checker: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rvalid != '0) begin
      if (sb.size() == 0) begin
        check("spurious_rvalid", 32'(rvalid), 32'd0);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        check("rvalid", 32'(rvalid), 32'(4'b0001 << e[15:8]));
        check("rdata", 32'(rdata), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int rr_order [5] = '{1, 2, 3, 0, 1};
  int lk_addr  [5] = '{15, 7, 3, 5, 4};

  initial begin
    rs = 1'b1; req = '0; lock = '0; addr_in = '0;
    tick(); tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(hold_expired), 32'd0);
    rs = 1'b0;

    // single unlocked read
    req = 4'b0100; set_addr(2, 5);
    tick();
    check("t1_gnt", 32'(gnt), 32'b0100);
    check("t1_addr", 32'(mem_addr), 32'd5);
    check("t1_busy", 32'(busy), 32'd1);
    push(2, 5);
    tick();
    req = '0; #1;
    check("t1_busy2", 32'(busy), 32'd1);
    check("t1_addr_idle", 32'(mem_addr), 32'd0);
    tick();
    check("t1_gnt_rel", 32'(gnt), 32'd0);
    tick(); tick();

    // round-robin from reset pointer
    rs = 1'b1; tick(); rs = 1'b0;
    for (int i = 0; i < NREQ; i++) set_addr(i, 20 + i);
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rr_gnt", 32'(gnt), 32'(4'b0001 << rr_order[k]));
      push(rr_order[k], 20 + rr_order[k]);
      tick();
    end
    req = '0;
    tick(); tick(); tick();

    // locked search with another requester pending
    req = 4'b0001; lock = 4'b0001; set_addr(0, 15); set_addr(3, 2);
    tick();
    req = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      set_addr(0, lk_addr[k]);
      if (k == 4) lock = '0;
      #1;
      check("lk_gnt", 32'(gnt), 32'b0001);
      check("lk_addr", 32'(mem_addr), 32'(lk_addr[k]));
      push(0, lk_addr[k]);
      tick();
    end
    req = '0;
    check("lk_next", 32'(gnt), 32'b1000);
    tick(); tick(); tick();

    // reset while a read is in flight
    req = 4'b0010; set_addr(1, 9);
    tick();
    check("rm_gnt", 32'(gnt), 32'b0010);
    tick();
    rs = 1'b1; req = 4'b0001;
    tick();
    check("rm_gnt0", 32'(gnt), 32'd0);
    check("rm_rvalid", 32'(rvalid), 32'd0);
    rs = 1'b0;
    tick();
    check("rm_next", 32'(gnt), 32'b0001);
    push(0, 4);
    tick();
    req = '0;
    tick(); tick(); tick();

    // owner drops req while lock stays high
    req = 4'b0001; lock = 4'b0001; set_addr(0, 10);
    tick();
    check("od_gnt", 32'(gnt), 32'b0001);
    push(0, 10);
    tick();
    req = 4'b0010; #1;
    check("od_addr", 32'(mem_addr), 32'd0);
    tick();
    check("od_next", 32'(gnt), 32'b0010);
    push(1, 9);
    tick();
    req = '0; lock = '0;
    tick(); tick(); tick();

    // hold limit behaviour
    req = 4'b0010; lock = 4'b0010; set_addr(1, 6); set_addr(2, 5);
    tick();
    req = 4'b0110;
`ifdef SEARCH_MEM_ARB_HOLD_LIMIT_EN
    for (int k = 0; k < 4; k++) begin
      check("hl_gnt", 32'(gnt), 32'b0010);
      check("hl_pulse0", 32'(hold_expired), 32'd0);
      push(1, 6);
      tick();
    end
    check("hl_switch", 32'(gnt), 32'b0100);
    check("hl_pulse", 32'(hold_expired), 32'd1);
    push(2, 5);
    tick();
    req = '0; lock = '0;
    check("hl_pulse_end", 32'(hold_expired), 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      check("hl_gnt", 32'(gnt), 32'b0010);
      check("hl_pulse0", 32'(hold_expired), 32'd0);
      push(1, 6);
      tick();
    end
    req = 4'b0100; lock = '0;
    tick();
    check("hl_switch", 32'(gnt), 32'b0100);
    push(2, 5);
    tick();
    req = '0;
`endif
    tick(); tick(); tick(); tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("end_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
